// File: rtl/nn_port_arbiter.sv
// Two-requester round-robin arbiter for the NeuralNetwork memory-mapped port.
// One transaction in flight; command writes (addr[15:14]==2'b11) wait out the busy handshake.
module nn_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int RD_W         = 16,
  parameter int RD_LAT       = 1,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_we,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  output logic [1:0]             rsp_valid,
  output logic [RD_W-1:0]        rsp_data,
  output logic                   cmd_timeout,
  output logic                   nn_write_enable,
  output logic [ADDR_W-1:0]      nn_write_addr,
  output logic [DATA_W-1:0]      nn_write_data,
  output logic [ADDR_W-1:0]      nn_read_addr,
  input  logic [RD_W-1:0]        nn_read_data,
  input  logic                   nn_busy
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, CMD_HI, CMD_LO} state_t;

  localparam int CW = $clog2(BUSY_TIMEOUT + RD_LAT + 2);
  localparam logic [CW-1:0] CNT_RD_LAST = CW'(RD_LAT);
  localparam logic [CW-1:0] CNT_TO_LAST = CW'(BUSY_TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          ptr, owner;
  logic          gnt_any, gnt_id;
  logic [1:0]    elig;

  // Grant: pointer first, then the other requester; writes need the network idle.
  always_comb begin
    elig      = req_valid & (~req_we | {2{~nn_busy}});
    gnt_any   = 1'b0;
    gnt_id    = ptr;
    req_ready = '0;
    if (state == IDLE) begin
      if (elig[ptr]) begin
        gnt_any = 1'b1;
        gnt_id  = ptr;
      end else if (elig[~ptr]) begin
        gnt_any = 1'b1;
        gnt_id  = ~ptr;
      end
    end
    if (gnt_any) req_ready[gnt_id] = 1'b1;
  end

  // READ spans RD_LAT+1 cycles: address held for RD_LAT, the final one registers the response.
  always_comb begin
    state_nxt   = state;
    cmd_timeout = 1'b0;
    case (state)
      IDLE:   if (gnt_any) state_nxt = req_we[gnt_id] ? WRITE : READ;
      WRITE:  state_nxt = (nn_write_addr[ADDR_W-1 -: 2] == 2'b11) ? CMD_HI : IDLE;
      READ:   if (cnt == CNT_RD_LAST) state_nxt = IDLE;
      CMD_HI: begin
        if (nn_busy) begin
          state_nxt = CMD_LO;
        end else if (cnt == CNT_TO_LAST) begin
          cmd_timeout = 1'b1;
          state_nxt   = IDLE;
        end
      end
      CMD_LO: if (!nn_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      ptr             <= 1'b0;
      owner           <= 1'b0;
      rsp_valid       <= '0;
      rsp_data        <= '0;
      nn_write_enable <= 1'b0;
      nn_write_addr   <= '0;
      nn_write_data   <= '0;
      nn_read_addr    <= '0;
    end else begin
      state           <= state_nxt;
      nn_write_enable <= 1'b0;
      rsp_valid       <= '0;
      if (state_nxt != state) cnt <= '0;
      else if (state == READ || state == CMD_HI) cnt <= cnt + 1'b1;
      if (gnt_any) begin
        ptr   <= ~gnt_id;
        owner <= gnt_id;
        if (req_we[gnt_id]) begin
          nn_write_enable <= 1'b1;
          nn_write_addr   <= req_addr[gnt_id];
          nn_write_data   <= req_wdata[gnt_id];
        end else begin
          nn_read_addr <= req_addr[gnt_id];
        end
      end
      if (state == READ && cnt == CNT_RD_LAST) begin
        rsp_valid[owner] <= 1'b1;
        rsp_data         <= nn_read_data;
      end
    end
  end

endmodule

// File: tb/tb_nn_port_arbiter.sv
// Bench for nn_port_arbiter: timeline model checked every cycle plus directed literal checks.
module tb_nn_port_arbiter;
  localparam int RD_LAT = 1;
  localparam int BT     = 16;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } txn_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [1:0]      req_valid = '0, req_we = '0;
  logic [1:0]      req_ready, rsp_valid;
  logic [1:0][15:0] req_addr = '0, req_wdata = '0;
  logic [15:0]     rsp_data, nn_write_addr, nn_write_data, nn_read_addr;
  logic [15:0]     nn_read_data = '0;
  logic            cmd_timeout, nn_write_enable;
  logic            nn_busy = 1'b0;

  nn_port_arbiter #(
    .ADDR_W(16), .DATA_W(16), .RD_W(16), .RD_LAT(RD_LAT), .BUSY_TIMEOUT(BT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .cmd_timeout(cmd_timeout),
    .nn_write_enable(nn_write_enable), .nn_write_addr(nn_write_addr),
    .nn_write_data(nn_write_data), .nn_read_addr(nn_read_addr),
    .nn_read_data(nn_read_data), .nn_busy(nn_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    if (a == 16'h0005) return 16'h0ABC;
    return a * 16'd3 + 16'h0100;
  endfunction

  // Registered read port: data follows the address by one cycle.
  always @(posedge clk) nn_read_data <= mem_f(nn_read_addr);

  int n_pass = 0, n_tot = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  txn_t q0[$], q1[$];

  task automatic push(input int r, input logic we, input logic [15:0] a, input logic [15:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.data = d;
    if (r == 0) q0.push_back(t);
    else q1.push_back(t);
  endtask

  initial begin : drv
    logic [1:0] took;
    forever begin
      @(negedge clk);
      took = req_valid & req_ready;
      @(posedge clk); #1;
      if (took[0] && q0.size() > 0) void'(q0.pop_front());
      if (took[1] && q1.size() > 0) void'(q1.pop_front());
      req_valid[0] = (q0.size() > 0);
      if (q0.size() > 0) begin
        req_we[0] = q0[0].we; req_addr[0] = q0[0].addr; req_wdata[0] = q0[0].data;
      end
      req_valid[1] = (q1.size() > 0);
      if (q1.size() > 0) begin
        req_we[1] = q1[0].we; req_addr[1] = q1[0].addr; req_wdata[1] = q1[0].data;
      end
    end
  end

  // Model state: times at which the port frees, pending command window, pending response.
  int          free_at = 0, cmd_w = 0, rsp_due = -1;
  bit          cmd_pend = 0, hi_seen = 0;
  logic        ptr_m = 1'b0, e_we = 1'b0;
  logic [15:0] e_wa = '0, e_wd = '0, e_ra = '0, rsp_val_m = '0;
  logic [1:0]  rsp_vec_m = '0;

  int          w_cyc[$], g_cyc[$], g_id[$], r_cyc[$], t_cyc[$];
  logic [15:0] w_addr[$], w_data[$], r_data[$];
  logic [1:0]  r_vec[$];

  initial begin : cmp
    logic [1:0]  elig, ex_rdy, ex_rv;
    logic        ex_to;
    int          g;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_timeout", 32'(cmd_timeout), 0);
        chk("rst_we", 32'(nn_write_enable), 0);
        chk("rst_waddr", 32'(nn_write_addr), 0);
        chk("rst_wdata", 32'(nn_write_data), 0);
        chk("rst_raddr", 32'(nn_read_addr), 0);
        free_at = 0; cmd_pend = 0; hi_seen = 0; ptr_m = 1'b0; rsp_due = -1;
        e_we = 1'b0; e_wa = '0; e_wd = '0; e_ra = '0;
      end else begin
        ex_to = 1'b0;
        if (cmd_pend && cyc > cmd_w) begin
          if (!hi_seen) begin
            if (nn_busy) hi_seen = 1;
            else if (cyc == cmd_w + BT) begin
              ex_to = 1'b1; cmd_pend = 0; free_at = cyc + 1;
            end
          end else if (!nn_busy) begin
            cmd_pend = 0; free_at = cyc + 1;
          end
        end
        elig = '0; ex_rdy = '0; g = -1;
        if (!cmd_pend && cyc >= free_at) begin
          for (int i = 0; i < 2; i++) elig[i] = req_valid[i] && (!req_we[i] || !nn_busy);
          if (elig[ptr_m]) g = int'(ptr_m);
          else if (elig[!ptr_m]) g = int'(!ptr_m);
          if (g >= 0) ex_rdy[g] = 1'b1;
        end
        ex_rv = (cyc == rsp_due) ? rsp_vec_m : 2'b00;
        chk("ready", 32'(req_ready), 32'(ex_rdy));
        chk("write_enable", 32'(nn_write_enable), 32'(e_we));
        chk("write_addr", 32'(nn_write_addr), 32'(e_wa));
        chk("write_data", 32'(nn_write_data), 32'(e_wd));
        chk("read_addr", 32'(nn_read_addr), 32'(e_ra));
        chk("rsp_valid", 32'(rsp_valid), 32'(ex_rv));
        chk("cmd_timeout", 32'(cmd_timeout), 32'(ex_to));
        if (ex_rv != 2'b00) chk("rsp_data", 32'(rsp_data), 32'(rsp_val_m));
        e_we = 1'b0;
        if (g >= 0) begin
          ptr_m = (g == 0);
          if (req_we[g]) begin
            e_we = 1'b1; e_wa = req_addr[g]; e_wd = req_wdata[g];
            if (req_addr[g][15:14] == 2'b11) begin
              cmd_pend = 1; cmd_w = cyc + 1; hi_seen = 0;
            end else begin
              free_at = cyc + 2;
            end
          end else begin
            e_ra      = req_addr[g];
            rsp_due   = cyc + RD_LAT + 2;
            rsp_vec_m = (g == 0) ? 2'b01 : 2'b10;
            rsp_val_m = mem_f(req_addr[g]);
            free_at   = cyc + RD_LAT + 2;
          end
        end
      end
      if (nn_write_enable) begin
        w_cyc.push_back(cyc); w_addr.push_back(nn_write_addr); w_data.push_back(nn_write_data);
      end
      if ((req_valid & req_ready) != 2'b00) begin
        g_cyc.push_back(cyc); g_id.push_back(req_ready[1] ? 1 : 0);
      end
      if (rsp_valid != 2'b00) begin
        r_cyc.push_back(cyc); r_vec.push_back(rsp_valid); r_data.push_back(rsp_data);
      end
      if (cmd_timeout) t_cyc.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic wait_size(input string name, input int which, input int target, input int limit);
    int k;
    k = 0;
    while (k < limit &&
           ((which == 0 && w_cyc.size() < target) || (which == 1 && g_cyc.size() < target) ||
            (which == 2 && t_cyc.size() < target))) begin
      tick(1);
      k++;
    end
    if (k == limit) chk(name, 0, 1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int nw, ng, nr, nt, fall;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);

    // Three plain writes from requester 0.
    nw = w_cyc.size();
    push(0, 1'b1, 16'h0002, 16'h1000);
    push(0, 1'b1, 16'h0003, 16'h1000);
    push(0, 1'b1, 16'h0004, 16'h1000);
    tick(12);
    chk("t1_count", 32'(w_cyc.size() - nw), 3);
    if (w_cyc.size() - nw == 3) begin
      for (int j = 0; j < 3; j++) begin
        chk("t1_addr", 32'(w_addr[nw+j]), 32'(j + 2));
        chk("t1_data", 32'(w_data[nw+j]), 32'h1000);
      end
      chk("t1_gap_a", 32'(w_cyc[nw+1] - w_cyc[nw]), 2);
      chk("t1_gap_b", 32'(w_cyc[nw+2] - w_cyc[nw+1]), 2);
    end

    // Requester 1 read; response three cycles after accept.
    ng = g_cyc.size(); nr = r_cyc.size();
    push(1, 1'b0, 16'h0005, 16'h0000);
    tick(8);
    chk("t5_grants", 32'(g_cyc.size() - ng), 1);
    chk("t5_rsps", 32'(r_cyc.size() - nr), 1);
    if (g_cyc.size() - ng == 1 && r_cyc.size() - nr == 1) begin
      chk("t5_gid", 32'(g_id[ng]), 1);
      chk("t5_vec", 32'(r_vec[nr]), 32'h2);
      chk("t5_data", 32'(r_data[nr]), 32'h0ABC);
      chk("t5_latency", 32'(r_cyc[nr] - g_cyc[ng]), 3);
    end

    // Both requesters write continuously: grants alternate 0,1,0,1...
    ng = g_cyc.size(); nw = w_cyc.size();
    for (int k = 0; k < 4; k++) begin
      push(0, 1'b1, 16'h0010 + 16'(k), 16'h0A00 + 16'(k));
      push(1, 1'b1, 16'h0020 + 16'(k), 16'h0B00 + 16'(k));
    end
    tick(22);
    chk("t2_grants", 32'(g_cyc.size() - ng), 8);
    if (g_cyc.size() - ng == 8 && w_cyc.size() - nw == 8) begin
      for (int j = 0; j < 8; j++) begin
        chk("t2_gid", 32'(g_id[ng+j]), 32'(j % 2));
        chk("t2_addr", 32'(w_addr[nw+j]), (j % 2 == 0) ? 32'(16 + j / 2) : 32'(32 + j / 2));
        if (j > 0) chk("t2_gap", 32'(g_cyc[ng+j] - g_cyc[ng+j-1]), 2);
      end
    end

    // Command write with busy handshake: no grants until the cycle after busy falls.
    nw = w_cyc.size(); ng = g_cyc.size(); nt = t_cyc.size();
    push(0, 1'b1, 16'hC005, 16'h0003);
    wait_size("t3_wait_cmd", 0, nw + 1, 10);
    push(1, 1'b1, 16'h0030, 16'h0030);
    tick(3);
    nn_busy = 1'b1;
    tick(20);
    nn_busy = 1'b0;
    fall = cyc + 1;
    chk("t3_no_grant_in_cmd", 32'(g_cyc.size() - ng), 1);
    wait_size("t3_wait_grant", 1, ng + 2, 10);
    if (g_cyc.size() - ng == 2) begin
      chk("t3_resume_cycle", 32'(g_cyc[ng+1]), 32'(fall + 1));
      chk("t3_resume_gid", 32'(g_id[ng+1]), 1);
    end
    chk("t3_no_timeout", 32'(t_cyc.size() - nt), 0);
    tick(4);

    // Command write with busy never rising: timeout 16 cycles after WRITE.
    nw = w_cyc.size(); ng = g_cyc.size(); nt = t_cyc.size();
    push(0, 1'b1, 16'hC005, 16'h0003);
    wait_size("t4_wait_cmd", 0, nw + 1, 10);
    push(1, 1'b1, 16'h0040, 16'h0040);
    wait_size("t4_wait_timeout", 2, nt + 1, 30);
    tick(4);
    chk("t4_to_count", 32'(t_cyc.size() - nt), 1);
    if (t_cyc.size() - nt == 1 && g_cyc.size() - ng == 2) begin
      chk("t4_to_delay", 32'(t_cyc[nt] - w_cyc[nw]), 16);
      chk("t4_resume_cycle", 32'(g_cyc[ng+1]), 32'(t_cyc[nt] + 1));
      chk("t4_resume_gid", 32'(g_id[ng+1]), 1);
    end
    tick(4);

    // Busy outside a command: the read is served, the write held until busy drops.
    nn_busy = 1'b1;
    tick(1);
    ng = g_cyc.size(); nr = r_cyc.size(); nw = w_cyc.size();
    push(0, 1'b1, 16'h0050, 16'h0055);
    push(1, 1'b0, 16'h0006, 16'h0000);
    tick(10);
    chk("t6_busy_grants", 32'(g_cyc.size() - ng), 1);
    chk("t6_busy_rsps", 32'(r_cyc.size() - nr), 1);
    if (g_cyc.size() - ng == 1 && r_cyc.size() - nr == 1) begin
      chk("t6_read_gid", 32'(g_id[ng]), 1);
      chk("t6_read_vec", 32'(r_vec[nr]), 32'h2);
      chk("t6_read_data", 32'(r_data[nr]), 32'h0112);
    end
    nn_busy = 1'b0;
    tick(6);
    chk("t6_write_released", 32'(w_cyc.size() - nw), 1);
    if (w_cyc.size() - nw == 1) chk("t6_write_addr", 32'(w_addr[nw]), 32'h0050);

    // Reset in the middle of a read: no response afterwards.
    ng = g_cyc.size(); nr = r_cyc.size();
    push(1, 1'b0, 16'h0007, 16'h0000);
    wait_size("t6_wait_read", 1, ng + 1, 10);
    reset = 1'b1;
    q0.delete(); q1.delete();
    tick(3);
    reset = 1'b0;
    tick(8);
    chk("t6_rst_no_rsp", 32'(r_cyc.size() - nr), 0);

    nr = r_cyc.size();
    push(0, 1'b0, 16'h0005, 16'h0000);
    tick(8);
    chk("t6_post_rst_rsps", 32'(r_cyc.size() - nr), 1);
    if (r_cyc.size() - nr == 1) begin
      chk("t6_post_rst_vec", 32'(r_vec[nr]), 32'h1);
      chk("t6_post_rst_data", 32'(r_data[nr]), 32'h0ABC);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
